irq_prio_arbiter: RTL and testbench
===================================

Name: irq_prio_arbiter

Overview:
- Sits between the per-line interrupt pending latches and the core's 32-bit irq input.
- Presents at most one interrupt line to the core at a time.
- Selection: highest programmed priority among enabled pending lines, round-robin among equal priorities.
- Config/status registers are accessed over a simple peripheral bus.
- On core acknowledge, pulses a clear back to the pending source.

Parameters:
- NUM_IRQ, 32, number of arbitrated lines (1..32); o_irq bits at or above NUM_IRQ are tied 0.
- TIMEOUT_CYC, 1024, grant-to-ack limit in cycles, used only with the optional feature.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_irq_req  in  32  pending levels from upstream latches; bit held until cleared.
- o_irq_clr  out  32  one-cycle clear pulse to upstream latch.
- o_irq  out  32  to core; one-hot or zero.
- i_irq_ack  in  1  core acknowledge strobe.
- i_irq_id  in  5  acknowledged line id.
- i_cfg_wren  in  1  register write strobe.
- i_cfg_rden  in  1  register read strobe.
- i_cfg_addr  in  2  word address.
- i_cfg_wdata  in  32  write data.
- o_cfg_rdata  out  32  read data.
- o_cfg_rvalid  out  1  read data valid.

Behaviour:
- Reset (i_rst high at a clock edge): all outputs 0, state IDLE, rr_ptr 0, ENABLE 0, PRIO 32'h5555_5555 (every line priority 1), THRESH 0. Reset during GRANT drops o_irq the next cycle; no o_irq_clr pulse.
- Registers:
  - addr0 ENABLE: RW.
  - addr1 PRIO_LO: RW; 2 bits per line, lines 0-15.
  - addr2 PRIO_HI: RW; lines 16-31.
  - addr3 CTRL: [1:0] THRESH RW; [8:4] current grant id RO; [12] busy RO; [16] timeout sticky (feature only, W1C).
- Reads return o_cfg_rdata with o_cfg_rvalid one cycle after i_cfg_rden.
- Writes take effect the cycle after i_cfg_wren. Arbitration in the same cycle as a write uses the old values.
- Eligible line i: i_irq_req[i] & ENABLE[i] & (prio[i] > THRESH) & i<NUM_IRQ.
- Selection:
  - Take the highest prio value among eligible lines.
  - Within that level, pick the first eligible index scanning from rr_ptr upward, wrapping at NUM_IRQ.
- FSM:
  - IDLE: if any line eligible, register grant id g, set o_irq[g]=1, go to GRANT. Candidates evaluated in cycle N appear on o_irq in cycle N+1.
  - GRANT: o_irq[g] held.
    - If i_irq_ack and i_irq_id==g at cycle M: o_irq clears and o_irq_clr[g] pulses at M+1; rr_ptr <= (g+1) mod NUM_IRQ; go to HOLD.
    - If i_irq_req[g] drops before ack: withdraw o_irq the next cycle, no clr pulse, rr_ptr unchanged, go to IDLE.
    - An ack with a mismatched id, or any ack outside GRANT, is ignored.
    - Clearing ENABLE[g] or changing prio/THRESH during GRANT does not revoke the grant.
  - HOLD: lasts one cycle so the upstream clear settles, then IDLE. Earliest next o_irq assertion is M+3.
- o_irq never has more than one bit set; o_irq_clr is never set while the same bit of o_irq is set.
- A new request arriving during GRANT/HOLD waits; it is not preempted.

Optional Feature:
- IRQ_TIMEOUT_EN defined:
  - A 16-bit counter starts at 0 on entry to GRANT and increments each GRANT cycle.
  - When it reaches TIMEOUT_CYC-1 without a matching ack: withdraw o_irq next cycle, no clr pulse, set CTRL[16], rr_ptr <= (g+1) mod NUM_IRQ, go to IDLE.
  - CTRL[16] is cleared by writing 1.
- IRQ_TIMEOUT_EN undefined: no counter; GRANT waits indefinitely; CTRL[16] reads 0 and writes to it are ignored.

Test Plan:
- Reset, ENABLE=32'h0000_0009, i_irq_req=32'h0000_0009, default prio -> o_irq=32'h1 one cycle later. Ack id 0 -> o_irq_clr=32'h1 next cycle. Drop req[0] -> o_irq=32'h8 three cycles after the ack.
- PRIO_LO sets line 5=3 and line 2=1, both enabled and requesting -> line 5 granted first, then line 2. With THRESH=1, line 2 is never granted.
- Lines 1, 4, 7 at equal prio, each held asserted and re-requested after its clear -> grant order 1,4,7,1 (round-robin wrap).
- In GRANT on line 3, ack with id 4 -> no change. Then drop req[3] -> o_irq=0 next cycle, o_irq_clr stays 0, state IDLE.
- Write ENABLE and assert a new request in the same cycle -> decision uses the old ENABLE. Read addr3 during GRANT of line 9 -> rdata[8:4]=9 and [12]=1, with o_cfg_rvalid one cycle after i_cfg_rden.
- IRQ_TIMEOUT_EN with TIMEOUT_CYC=8, no ack -> o_irq drops after 8 GRANT cycles, CTRL[16]=1. Writing 32'h1_0000 to addr3 clears it.

Source files
------------

// File: rtl/irq_prio_arbiter_if.sv
// Interrupt line, core acknowledge and config bus bundle for irq_prio_arbiter.
interface irq_prio_arbiter_if;
   logic [31:0] i_irq_req;
   logic [31:0] o_irq_clr;
   logic [31:0] o_irq;
   logic        i_irq_ack;
   logic [4:0]  i_irq_id;
   logic        i_cfg_wren;
   logic        i_cfg_rden;
   logic [1:0]  i_cfg_addr;
   logic [31:0] i_cfg_wdata;
   logic [31:0] o_cfg_rdata;
   logic        o_cfg_rvalid;

   modport slave (
      input  i_irq_req, i_irq_ack, i_irq_id,
      input  i_cfg_wren, i_cfg_rden, i_cfg_addr, i_cfg_wdata,
      output o_irq_clr, o_irq, o_cfg_rdata, o_cfg_rvalid
   );

   modport master (
      output i_irq_req, i_irq_ack, i_irq_id,
      output i_cfg_wren, i_cfg_rden, i_cfg_addr, i_cfg_wdata,
      input  o_irq_clr, o_irq, o_cfg_rdata, o_cfg_rvalid
   );
endinterface

// File: rtl/irq_prio_arbiter.sv
// Priority/round-robin interrupt arbiter presenting one line at a time to the core.
// Optional grant timeout enabled by defining IRQ_TIMEOUT_EN.
module irq_prio_arbiter #(
   parameter int NUM_IRQ     = 32,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              i_clk,
   input  logic              i_rst,
   irq_prio_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   localparam logic [31:0] LINE_MASK = (NUM_IRQ >= 32) ? 32'hFFFF_FFFF
                                                       : ((32'd1 << NUM_IRQ) - 32'd1);
   localparam logic [4:0]  LAST_IDX  = 5'(NUM_IRQ - 1);

   if ((NUM_IRQ < 1) || (NUM_IRQ > 32) || (TIMEOUT_CYC < 2) || (TIMEOUT_CYC > 65536)) begin : g_bad_param
      $error("irq_prio_arbiter: parameter out of range");
   end

   function automatic logic [4:0] next_idx(input logic [4:0] idx);
      logic [4:0] res;
      if (idx >= LAST_IDX) begin
         res = 5'd0;
      end else begin
         res = idx + 5'd1;
      end
      return res;
   endfunction

   state_e      state_q,    state_d;
   logic [31:0] enable_q,   enable_d;
   logic [63:0] prio_q,     prio_d;
   logic [1:0]  thresh_q,   thresh_d;
   logic [4:0]  grant_q,    grant_d;
   logic [4:0]  rr_ptr_q,   rr_ptr_d;
   logic [31:0] irq_q,      irq_d;
   logic [31:0] irq_clr_q,  irq_clr_d;
   logic [31:0] rdata_q,    rdata_d;
   logic        rvalid_q,   rvalid_d;

   logic [31:0] elig_s;
   logic [1:0]  top_prio_s;
   logic        any_elig_s;
   logic [4:0]  sel_id_s;
   logic        sel_found_s;
   logic [5:0]  idx_s;
   logic        ack_hit_s;
   logic        req_g_s;
   logic        tmo_hit_s;
   logic        tmo_flag_s;
   logic        busy_s;
   logic [31:0] ctrl_s;

   assign ack_hit_s = bus.i_irq_ack && (bus.i_irq_id == grant_q);
   assign req_g_s   = bus.i_irq_req[grant_q];
   assign busy_s    = (state_q != ST_IDLE);

`ifdef IRQ_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

   logic [15:0] tcnt_q, tcnt_d;
   logic        tmo_flag_q, tmo_flag_d;

   assign tmo_hit_s  = (state_q == ST_GRANT) && (tcnt_q == TMO_LAST);
   assign tmo_flag_s = tmo_flag_q;

   // Grant-age counter and sticky timeout flag; a timeout set beats a same-cycle W1C.
   always_comb begin
      if (state_q == ST_GRANT) begin
         tcnt_d = tcnt_q + 16'd1;
      end else begin
         tcnt_d = 16'd0;
      end
      tmo_flag_d = tmo_flag_q;
      if (bus.i_cfg_wren && (bus.i_cfg_addr == 2'd3) && bus.i_cfg_wdata[16]) begin
         tmo_flag_d = 1'b0;
      end else begin
         tmo_flag_d = tmo_flag_q;
      end
      if (tmo_hit_s && !ack_hit_s && req_g_s) begin
         tmo_flag_d = 1'b1;
      end else begin
         tmo_flag_d = tmo_flag_d;
      end
   end

   // Timeout state registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tcnt_q     <= 16'd0;
         tmo_flag_q <= 1'b0;
      end else begin
         tcnt_q     <= tcnt_d;
         tmo_flag_q <= tmo_flag_d;
      end
   end
`else
   assign tmo_hit_s  = 1'b0;
   assign tmo_flag_s = 1'b0;
`endif

   // Candidate selection: highest priority level, then first hit at or after rr_ptr.
   always_comb begin
      elig_s      = 32'd0;
      top_prio_s  = 2'd0;
      sel_id_s    = 5'd0;
      sel_found_s = 1'b0;
      idx_s       = 6'd0;
      for (int i = 0; i < 32; i++) begin
         if (LINE_MASK[i] && bus.i_irq_req[i] && enable_q[i] && (prio_q[2*i +: 2] > thresh_q)) begin
            elig_s[i] = 1'b1;
         end else begin
            elig_s[i] = 1'b0;
         end
      end
      for (int i = 0; i < 32; i++) begin
         if (elig_s[i] && (prio_q[2*i +: 2] > top_prio_s)) begin
            top_prio_s = prio_q[2*i +: 2];
         end else begin
            top_prio_s = top_prio_s;
         end
      end
      for (int k = 0; k < NUM_IRQ; k++) begin
         idx_s = {1'b0, rr_ptr_q} + 6'(k);
         if (idx_s >= 6'(NUM_IRQ)) begin
            idx_s = idx_s - 6'(NUM_IRQ);
         end else begin
            idx_s = idx_s;
         end
         if (!sel_found_s && elig_s[idx_s[4:0]] && (prio_q[{idx_s[4:0], 1'b0} +: 2] == top_prio_s)) begin
            sel_id_s    = idx_s[4:0];
            sel_found_s = 1'b1;
         end else begin
            sel_found_s = sel_found_s;
         end
      end
      any_elig_s = |elig_s;
   end

   // FSM next state; a matching ack wins over a same-cycle request drop or timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (any_elig_s) begin
               state_d = ST_GRANT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (ack_hit_s) begin
               state_d = ST_HOLD;
            end else if (!req_g_s || tmo_hit_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_GRANT;
            end
         end
         ST_HOLD: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: grant id, one-hot irq, clear pulse and round-robin pointer.
   always_comb begin
      grant_d   = grant_q;
      irq_d     = 32'd0;
      irq_clr_d = 32'd0;
      rr_ptr_d  = rr_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (any_elig_s) begin
               grant_d = sel_id_s;
               irq_d   = (32'd1 << sel_id_s) & LINE_MASK;
            end else begin
               irq_d   = 32'd0;
            end
         end
         ST_GRANT: begin
            if (ack_hit_s) begin
               irq_clr_d = (32'd1 << grant_q) & LINE_MASK;
               rr_ptr_d  = next_idx(grant_q);
            end else if (!req_g_s) begin
               irq_d     = 32'd0;
            end else if (tmo_hit_s) begin
               rr_ptr_d  = next_idx(grant_q);
            end else begin
               irq_d     = irq_q;
            end
         end
         ST_HOLD: irq_d = 32'd0;
         default: irq_d = 32'd0;
      endcase
   end

   // Config register writes and registered read port.
   always_comb begin
      enable_d = enable_q;
      prio_d   = prio_q;
      thresh_d = thresh_q;
      ctrl_s   = {15'd0, tmo_flag_s, 3'd0, busy_s, 3'd0,
                  (busy_s ? grant_q : 5'd0), 2'd0, thresh_q};
      if (bus.i_cfg_wren) begin
         case (bus.i_cfg_addr)
            2'd0:    enable_d      = bus.i_cfg_wdata;
            2'd1:    prio_d[31:0]  = bus.i_cfg_wdata;
            2'd2:    prio_d[63:32] = bus.i_cfg_wdata;
            2'd3:    thresh_d      = bus.i_cfg_wdata[1:0];
            default: enable_d      = enable_q;
         endcase
      end else begin
         enable_d = enable_q;
      end
      rvalid_d = bus.i_cfg_rden;
      if (bus.i_cfg_rden) begin
         case (bus.i_cfg_addr)
            2'd0:    rdata_d = enable_q;
            2'd1:    rdata_d = prio_q[31:0];
            2'd2:    rdata_d = prio_q[63:32];
            2'd3:    rdata_d = ctrl_s;
            default: rdata_d = 32'd0;
         endcase
      end else begin
         rdata_d = 32'd0;
      end
   end

   // State and output registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         enable_q  <= 32'd0;
         prio_q    <= 64'h5555_5555_5555_5555;
         thresh_q  <= 2'd0;
         grant_q   <= 5'd0;
         rr_ptr_q  <= 5'd0;
         irq_q     <= 32'd0;
         irq_clr_q <= 32'd0;
         rdata_q   <= 32'd0;
         rvalid_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         enable_q  <= enable_d;
         prio_q    <= prio_d;
         thresh_q  <= thresh_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         irq_q     <= irq_d;
         irq_clr_q <= irq_clr_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
      end
   end

   assign bus.o_irq        = irq_q;
   assign bus.o_irq_clr    = irq_clr_q;
   assign bus.o_cfg_rdata  = rdata_q;
   assign bus.o_cfg_rvalid = rvalid_q;

endmodule

// File: tb/tb_irq_prio_arbiter.sv
// Directed bench for irq_prio_arbiter: register and arbitration vector tables
// plus hand-written multi-cycle sequences (ack, withdraw, round-robin, timeout).
module tb_irq_prio_arbiter;

`ifdef IRQ_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 1024;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   irq_prio_arbiter_if bus_if ();

   irq_prio_arbiter #(.NUM_IRQ(32), .TIMEOUT_CYC(TMO)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        do_wr;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } reg_vec_t;

   typedef struct {
      logic [31:0] en;
      logic [31:0] plo;
      logic [31:0] phi;
      logic [1:0]  thr;
      logic [31:0] req;
      logic [31:0] exp;
   } arb_vec_t;

   reg_vec_t reg_tab [10];
   arb_vec_t arb_tab [10];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst                = 1'b1;
      bus_if.i_irq_req   = 32'd0;
      bus_if.i_irq_ack   = 1'b0;
      bus_if.i_irq_id    = 5'd0;
      bus_if.i_cfg_wren  = 1'b0;
      bus_if.i_cfg_rden  = 1'b0;
      bus_if.i_cfg_addr  = 2'd0;
      bus_if.i_cfg_wdata = 32'd0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
      bus_if.i_cfg_wren  = 1'b1;
      bus_if.i_cfg_addr  = addr;
      bus_if.i_cfg_wdata = data;
      tick();
      bus_if.i_cfg_wren  = 1'b0;
   endtask

   task automatic cfg_read(input logic [1:0] addr, output logic [31:0] data);
      bus_if.i_cfg_rden = 1'b1;
      bus_if.i_cfg_addr = addr;
      tick();
      bus_if.i_cfg_rden = 1'b0;
      check("rvalid", {31'd0, bus_if.o_cfg_rvalid}, 32'd1);
      data = bus_if.o_cfg_rdata;
   endtask

   // Ack id, then expect clear pulse, a quiet HOLD cycle and the next grant.
   task automatic ack_seq(input logic [4:0] id, input logic [31:0] exp_clr,
                          input logic [31:0] new_req, input logic [31:0] exp_next,
                          input string nm);
      bus_if.i_irq_ack = 1'b1;
      bus_if.i_irq_id  = id;
      tick();
      bus_if.i_irq_ack = 1'b0;
      check({nm, "_clr"}, bus_if.o_irq_clr, exp_clr);
      check({nm, "_irq_drop"}, bus_if.o_irq, 32'd0);
      bus_if.i_irq_req = new_req;
      tick();
      check({nm, "_hold"}, bus_if.o_irq | bus_if.o_irq_clr, 32'd0);
      tick();
      check({nm, "_next"}, bus_if.o_irq, exp_next);
   endtask

   initial begin
      logic [31:0] rd;
      checks   = 0;
      failures = 0;

      reg_tab[0] = '{1'b0, 2'd0, 32'd0,         32'h0000_0000};
      reg_tab[1] = '{1'b0, 2'd1, 32'd0,         32'h5555_5555};
      reg_tab[2] = '{1'b0, 2'd2, 32'd0,         32'h5555_5555};
      reg_tab[3] = '{1'b0, 2'd3, 32'd0,         32'h0000_0000};
      reg_tab[4] = '{1'b1, 2'd0, 32'hA5A5_0F0F, 32'hA5A5_0F0F};
      reg_tab[5] = '{1'b1, 2'd1, 32'h1234_5678, 32'h1234_5678};
      reg_tab[6] = '{1'b1, 2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      reg_tab[7] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0000_0003};
      reg_tab[8] = '{1'b1, 2'd3, 32'h0000_0002, 32'h0000_0002};
      reg_tab[9] = '{1'b1, 2'd0, 32'h0000_0000, 32'h0000_0000};

      arb_tab[0] = '{32'h0000_0009, 32'h5555_5555, 32'h5555_5555, 2'd0, 32'h0000_0009, 32'h0000_0001};
      arb_tab[1] = '{32'h0000_0024, 32'h5555_5D55, 32'h5555_5555, 2'd0, 32'h0000_0024, 32'h0000_0020};
      arb_tab[2] = '{32'h0000_0024, 32'h5555_5D55, 32'h5555_5555, 2'd1, 32'h0000_0004, 32'h0000_0000};
      arb_tab[3] = '{32'hFFFF_FFFF, 32'h5555_5555, 32'h6555_5555, 2'd0, 32'hF000_0000, 32'h4000_0000};
      arb_tab[4] = '{32'h0000_0000, 32'h5555_5555, 32'h5555_5555, 2'd0, 32'hFFFF_FFFF, 32'h0000_0000};
      arb_tab[5] = '{32'h0000_0001, 32'h5555_5554, 32'h5555_5555, 2'd0, 32'h0000_0001, 32'h0000_0000};
      arb_tab[6] = '{32'h0000_0080, 32'hFFFF_FFFF, 32'h5555_5555, 2'd3, 32'h0000_0080, 32'h0000_0000};
      arb_tab[7] = '{32'h0000_0C00, 32'hFFFF_FFFF, 32'h5555_5555, 2'd2, 32'h0000_0C00, 32'h0000_0400};
      arb_tab[8] = '{32'hFFFF_FFFF, 32'h5555_5555, 32'h5555_5555, 2'd0, 32'h8000_0000, 32'h8000_0000};
      arb_tab[9] = '{32'h0000_00FF, 32'h5555_6555, 32'h5555_5555, 2'd0, 32'h0000_00C1, 32'h0000_0040};

      @(negedge clk);
      do_reset();
      check("rst_irq",    bus_if.o_irq,        32'd0);
      check("rst_clr",    bus_if.o_irq_clr,    32'd0);
      check("rst_rdata",  bus_if.o_cfg_rdata,  32'd0);
      check("rst_rvalid", {31'd0, bus_if.o_cfg_rvalid}, 32'd0);

      for (int i = 0; i < 10; i++) begin
         if (reg_tab[i].do_wr) begin
            cfg_write(reg_tab[i].addr, reg_tab[i].wdata);
         end
         cfg_read(reg_tab[i].addr, rd);
         check($sformatf("reg_vec%0d", i), rd, reg_tab[i].exp);
      end

      for (int i = 0; i < 10; i++) begin
         do_reset();
         cfg_write(2'd0, arb_tab[i].en);
         cfg_write(2'd1, arb_tab[i].plo);
         cfg_write(2'd2, arb_tab[i].phi);
         cfg_write(2'd3, {30'd0, arb_tab[i].thr});
         bus_if.i_irq_req = arb_tab[i].req;
         tick();
         check($sformatf("arb_vec%0d_irq", i), bus_if.o_irq, arb_tab[i].exp);
         check($sformatf("arb_vec%0d_clr", i), bus_if.o_irq_clr, 32'd0);
      end

      // Basic grant, ack, clear and next grant three cycles after the ack.
      do_reset();
      cfg_write(2'd0, 32'h0000_0009);
      bus_if.i_irq_req = 32'h0000_0009;
      tick();
      check("basic_grant", bus_if.o_irq, 32'h0000_0001);
      ack_seq(5'd0, 32'h0000_0001, 32'h0000_0008, 32'h0000_0008, "basic");

      // Priority 3 line beats priority 1 line, lower one follows.
      do_reset();
      cfg_write(2'd0, 32'h0000_0024);
      cfg_write(2'd1, 32'h5555_5D55);
      bus_if.i_irq_req = 32'h0000_0024;
      tick();
      check("prio_first", bus_if.o_irq, 32'h0000_0020);
      ack_seq(5'd5, 32'h0000_0020, 32'h0000_0004, 32'h0000_0004, "prio");

      // Round robin 1, 4, 7 then wrap to 1 with requests held.
      do_reset();
      cfg_write(2'd0, 32'h0000_0092);
      bus_if.i_irq_req = 32'h0000_0092;
      tick();
      check("rr_first", bus_if.o_irq, 32'h0000_0002);
      ack_seq(5'd1, 32'h0000_0002, 32'h0000_0092, 32'h0000_0010, "rr1");
      ack_seq(5'd4, 32'h0000_0010, 32'h0000_0092, 32'h0000_0080, "rr4");
      ack_seq(5'd7, 32'h0000_0080, 32'h0000_0092, 32'h0000_0002, "rr7");

      // Mismatched ack ignored, then request withdrawal.
      do_reset();
      cfg_write(2'd0, 32'h0000_0008);
      bus_if.i_irq_req = 32'h0000_0008;
      tick();
      check("wd_grant", bus_if.o_irq, 32'h0000_0008);
      bus_if.i_irq_ack = 1'b1;
      bus_if.i_irq_id  = 5'd4;
      tick();
      bus_if.i_irq_ack = 1'b0;
      check("wd_badack_irq", bus_if.o_irq, 32'h0000_0008);
      check("wd_badack_clr", bus_if.o_irq_clr, 32'd0);
      bus_if.i_irq_req = 32'd0;
      tick();
      check("wd_drop_irq", bus_if.o_irq, 32'd0);
      check("wd_drop_clr", bus_if.o_irq_clr, 32'd0);
      cfg_read(2'd3, rd);
      check("wd_idle_ctrl", rd, 32'd0);

      // Same-cycle ENABLE write uses old value; CTRL readback during grant of line 9.
      do_reset();
      bus_if.i_cfg_wren  = 1'b1;
      bus_if.i_cfg_addr  = 2'd0;
      bus_if.i_cfg_wdata = 32'h0000_0200;
      bus_if.i_irq_req   = 32'h0000_0200;
      tick();
      bus_if.i_cfg_wren  = 1'b0;
      check("wr_old_enable", bus_if.o_irq, 32'd0);
      tick();
      check("wr_new_enable", bus_if.o_irq, 32'h0000_0200);
      cfg_read(2'd3, rd);
      check("ctrl_in_grant", rd, 32'h0000_1090);
      tick();
      check("rvalid_pulse", {31'd0, bus_if.o_cfg_rvalid}, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_grant_irq", bus_if.o_irq, 32'd0);
      check("rst_grant_clr", bus_if.o_irq_clr, 32'd0);
      cfg_read(2'd0, rd);
      check("rst_grant_en", rd, 32'd0);

`ifdef IRQ_TIMEOUT_EN
      // Unacknowledged grant is withdrawn after TMO cycles and flags CTRL[16].
      do_reset();
      cfg_write(2'd0, 32'h0000_0001);
      bus_if.i_irq_req = 32'h0000_0001;
      tick();
      check("tmo_grant", bus_if.o_irq, 32'h0000_0001);
      for (int k = 0; k < TMO - 1; k++) begin
         tick();
         check($sformatf("tmo_hold%0d", k), bus_if.o_irq, 32'h0000_0001);
      end
      tick();
      check("tmo_drop_irq", bus_if.o_irq, 32'd0);
      check("tmo_drop_clr", bus_if.o_irq_clr, 32'd0);
      bus_if.i_irq_req = 32'd0;
      tick();
      cfg_read(2'd3, rd);
      check("tmo_flag_set", rd, 32'h0001_0000);
      cfg_write(2'd3, 32'h0001_0000);
      cfg_read(2'd3, rd);
      check("tmo_flag_clr", rd, 32'd0);
`else
      // Without the timeout feature CTRL[16] is not writable and grants persist.
      do_reset();
      cfg_write(2'd3, 32'h0001_0000);
      cfg_read(2'd3, rd);
      check("no_tmo_flag", rd, 32'd0);
      cfg_write(2'd0, 32'h0000_0001);
      bus_if.i_irq_req = 32'h0000_0001;
      for (int k = 0; k < 40; k++) begin
         tick();
      end
      check("no_tmo_held", bus_if.o_irq, 32'h0000_0001);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
